// File: rtl/auth_keypad_entry_if.sv
// Keypad/programming/result signal bundle shared by the keypad entry block and its driver.
interface auth_keypad_entry_if #(
    parameter int N = 8
) ();
    localparam int FW = $clog2(N) + 1;

    logic          start;
    logic [FW-1:0] flat_in;
    logic          key_valid;
    logic [3:0]    key_data;
    logic          prog_en;
    logic [FW-1:0] prog_flat;
    logic [15:0]   prog_pin;
    logic          pwd_flag;
    logic [FW-1:0] flat_number;
    logic          auth_done;
    logic          busy;
    logic          locked;

    modport master (
        output start, flat_in, key_valid, key_data, prog_en, prog_flat, prog_pin,
        input  pwd_flag, flat_number, auth_done, busy, locked
    );

    modport slave (
        input  start, flat_in, key_valid, key_data, prog_en, prog_flat, prog_pin,
        output pwd_flag, flat_number, auth_done, busy, locked
    );
endinterface

// File: rtl/auth_keypad_entry.sv
// Four-digit PIN entry and check against a per-flat PIN table, with idle timeout.
// Define AUTH_LOCKOUT_EN to add the failure counter and timed LOCK after 3 consecutive failures.
module auth_keypad_entry #(
    parameter int N           = 8,
    parameter int TIMEOUT     = 1000,
    parameter int LOCK_CYCLES = 5000
) (
    input  logic                  clk,
    input  logic                  rst,
    auth_keypad_entry_if.slave    bus
);
    localparam int FW    = $clog2(N) + 1;
    localparam int NSLOT = N + 1;
    localparam int TMAX  = (TIMEOUT > LOCK_CYCLES) ? TIMEOUT : LOCK_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);

`ifdef AUTH_LOCKOUT_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_CHECK   = 3'd2,
        S_RESULT  = 3'd3,
        S_LOCK    = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_CHECK   = 3'd2,
        S_RESULT  = 3'd3
    } state_t;
`endif

    state_t        r_state;
    state_t        w_next;
    logic [FW-1:0] r_flat;
    logic [FW-1:0] r_flat_number;
    logic [15:0]   r_digits;
    logic [2:0]    r_dcnt;
    logic [TW-1:0] r_timer;
    logic          r_match;
    logic [15:0]   r_pin_table [NSLOT];

    logic          w_key_ok;
    logic          w_last_key;
    logic          w_timeout;
    logic          w_flat_ok;
    logic [15:0]   w_pin;
    logic          w_match;

`ifdef AUTH_LOCKOUT_EN
    logic [1:0]    r_fail_cnt;
    logic          w_lock_done;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    assign w_lock_done = (r_timer == TW'(LOCK_CYCLES - 1));
`endif

    // Digits outside 0-9 are noise from the keypad and never advance the entry.
    assign w_key_ok   = bus.key_valid && (bus.key_data <= 4'd9);
    assign w_last_key = w_key_ok && (r_dcnt == 3'd3);
    assign w_timeout  = !w_key_ok && (r_timer == TW'(TIMEOUT - 1));
    assign w_flat_ok  = (r_flat != '0) && (int'(r_flat) <= N + 1);
    assign w_match    = w_flat_ok && (r_digits == w_pin);

    always_comb begin
        w_pin = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (int'(r_flat) == i + 1) begin
                w_pin = r_pin_table[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_last_key || w_timeout) begin
                    w_next = w_last_key ? S_CHECK : S_RESULT;
                end
            end
            S_CHECK: begin
                w_next = S_RESULT;
            end
            S_RESULT: begin
`ifdef AUTH_LOCKOUT_EN
                w_next = (r_fail_cnt == 2'd3) ? S_LOCK : S_IDLE;
`else
                w_next = S_IDLE;
`endif
            end
`ifdef AUTH_LOCKOUT_EN
            S_LOCK: begin
                if (w_lock_done) begin
                    w_next = S_IDLE;
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.auth_done   = (r_state == S_RESULT);
        bus.pwd_flag    = (r_state == S_RESULT) && r_match;
        bus.flat_number = r_flat_number;
        bus.busy        = (r_state != S_IDLE);
`ifdef AUTH_LOCKOUT_EN
        bus.locked      = (r_state == S_LOCK);
`else
        bus.locked      = 1'b0;
`endif
    end

    // Table writes are independent of the FSM; a CHECK in the same cycle still sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                r_pin_table[i] <= 16'h0000;
            end
        end else if (bus.prog_en) begin
            for (int i = 0; i < NSLOT; i++) begin
                if (int'(bus.prog_flat) == i + 1) begin
                    r_pin_table[i] <= bus.prog_pin;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flat        <= '0;
            r_flat_number <= '0;
            r_digits      <= '0;
            r_dcnt        <= '0;
            r_timer       <= '0;
            r_match       <= 1'b0;
`ifdef AUTH_LOCKOUT_EN
            r_fail_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_flat   <= bus.flat_in;
                        r_digits <= '0;
                        r_dcnt   <= '0;
                        r_timer  <= '0;
                    end
                end
                S_COLLECT: begin
                    if (w_key_ok) begin
                        r_digits <= {r_digits[11:0], bus.key_data};
                        r_dcnt   <= r_dcnt + 3'd1;
                        r_timer  <= '0;
                    end else if (w_timeout) begin
                        r_match       <= 1'b0;
                        r_flat_number <= r_flat;
`ifdef AUTH_LOCKOUT_EN
                        r_fail_cnt    <= sat_inc2(r_fail_cnt);
`endif
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_CHECK: begin
                    r_match       <= w_match;
                    r_flat_number <= r_flat;
`ifdef AUTH_LOCKOUT_EN
                    r_fail_cnt    <= w_match ? 2'd0 : sat_inc2(r_fail_cnt);
`endif
                end
                S_RESULT: begin
                    r_timer <= '0;
                end
`ifdef AUTH_LOCKOUT_EN
                S_LOCK: begin
                    if (w_lock_done) begin
                        r_timer    <= '0;
                        r_fail_cnt <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
`endif
                default: begin
                    r_timer <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/auth_keypad_entry.md
AUTH_KEYPAD_ENTRY -- requirements
Module: auth_keypad_entry

Interface
REQ-001 SHALL have parameter N, default 8: number of reserved slots; valid flats are 1..N+1.
REQ-002 SHALL have parameter TIMEOUT, default 1000: maximum idle cycles between keys.
REQ-003 SHALL have parameter LOCK_CYCLES, default 5000: lockout duration in cycles.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that begins an entry attempt.
REQ-007 SHALL have port flat_in, input, $clog2(N)+1: flat number, sampled on start.
REQ-008 SHALL have port key_valid, input, 1: a keypad digit is present this cycle.
REQ-009 SHALL have port key_data, input, 4: BCD digit 0-9.
REQ-010 SHALL have port prog_en, input, 1: write a PIN into the table.
REQ-011 SHALL have port prog_flat, input, $clog2(N)+1: flat number to program.
REQ-012 SHALL have port prog_pin, input, 16: four BCD digits, most significant digit first.
REQ-013 SHALL have port pwd_flag, output, 1: PIN matched; held for the result cycle only.
REQ-014 SHALL have port flat_number, output, $clog2(N)+1: latched flat; feeds the reserved-entry stage.
REQ-015 SHALL have port auth_done, output, 1: one-cycle pulse that qualifies pwd_flag and flat_number.
REQ-016 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-017 SHALL have port locked, output, 1: high while in LOCK.

Function
REQ-018 SHALL implement the states IDLE, COLLECT, CHECK, RESULT and LOCK.
REQ-019 SHALL, in IDLE with start high, latch flat_in, clear the digit counter and timer, and go to COLLECT; start outside IDLE SHALL be ignored.
REQ-020 SHALL, in COLLECT, shift each key_valid digit into a 16-bit register (new digit enters the low nibble); a key_data value above 9 SHALL be discarded without counting.
REQ-021 SHALL go from COLLECT to CHECK on the cycle after the 4th valid digit; extra keys arriving in CHECK or RESULT SHALL be ignored.
REQ-022 SHALL restart the timer on every accepted digit; timer reaching TIMEOUT in COLLECT SHALL end the attempt as a failure: auth_done=1, pwd_flag=0, state goes to RESULT.
REQ-023 SHALL, in CHECK, compare the collected digits with pin_table[flat-1]; a flat equal to 0 or greater than N+1 SHALL count as a mismatch.
REQ-024 SHALL, in RESULT, hold auth_done=1 for exactly one cycle, with pwd_flag=match and flat_number=latched flat, then return to IDLE.
REQ-025 SHALL make the latency from the 4th digit to auth_done exactly 2 cycles.
REQ-026 SHALL, on a match, clear the failure counter.
REQ-027 SHALL, on a mismatch or timeout, increment a saturating 2-bit failure counter.
REQ-028 SHALL, on prog_en, write pin_table[prog_flat-1] in any state; an out-of-range prog_flat SHALL be ignored.
REQ-029 SHALL, when prog_en targets the flat being checked in the same cycle as CHECK, compare against the old table value.
REQ-030 SHALL hold flat_number at its last value outside RESULT; pwd_flag SHALL be 0 outside RESULT.

Reset
REQ-031 SHALL, on rst, put the FSM in IDLE and set pwd_flag=0, auth_done=0, busy=0, locked=0, flat_number=0, failure counter=0 and timer=0.
REQ-032 SHALL, on rst, initialise every pin_table entry to 16'h0000.
REQ-033 SHALL, on rst mid-attempt or mid-lockout, abort with no auth_done pulse.

Configuration
REQ-034 SHALL use the macro AUTH_LOCKOUT_EN.
REQ-035 SHALL, with AUTH_LOCKOUT_EN defined, make the 3rd consecutive failure enter LOCK after RESULT instead of IDLE.
REQ-036 SHALL, in LOCK, ignore start, hold locked=1 for LOCK_CYCLES cycles, then clear the failure counter and return to IDLE.
REQ-037 SHALL, without AUTH_LOCKOUT_EN, remove the LOCK state and the failure counter, tie locked to 0, and always return from RESULT to IDLE.

Verification
REQ-038 SHALL cover: prog flat 3 = 16'h1234; start with flat_in=3; keys 1,2,3,4 -> auth_done 2 cycles after the last key, pwd_flag=1, flat_number=3.
REQ-039 SHALL cover: same setup with keys 1,2,3,5 -> auth_done=1, pwd_flag=0, failure counter=1.
REQ-040 SHALL cover: flat_in=N+2 with any 4 keys -> pwd_flag=0; flat_in=0 -> pwd_flag=0.
REQ-041 SHALL cover: 2 keys, then TIMEOUT idle cycles -> auth_done with pwd_flag=0; the next start is accepted.
REQ-042 SHALL cover, with AUTH_LOCKOUT_EN: 3 wrong PINs -> locked=1 for 5000 cycles with start ignored, then a correct PIN -> pwd_flag=1; without the macro locked stays 0.
REQ-043 SHALL cover: rst asserted after the 3rd key -> no auth_done, outputs at reset values, busy=0 on the next cycle.
